// File: rtl/rr_arbiter_four_pkg.sv
// Shared constants for the four-way round-robin arbiter: FSM encodings and one-hot/index mapping.
// Combinational helpers only; no state.
package rr_arbiter_four_pkg;

  localparam int NUM_REQ = 4;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [3:0] OH_0 = 4'b0001;
  localparam logic [3:0] OH_1 = 4'b0010;
  localparam logic [3:0] OH_2 = 4'b0100;
  localparam logic [3:0] OH_3 = 4'b1000;

  localparam logic [1:0] IDX_0 = 2'd0;
  localparam logic [1:0] IDX_1 = 2'd1;
  localparam logic [1:0] IDX_2 = 2'd2;
  localparam logic [1:0] IDX_3 = 2'd3;

  function automatic logic [3:0] idx_to_oh(input logic [1:0] idx);
    logic [3:0] oh;
    oh = OH_0;
    case (idx)
      IDX_1:   oh = OH_1;
      IDX_2:   oh = OH_2;
      IDX_3:   oh = OH_3;
      default: oh = OH_0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/rr_arbiter_four_pick4.sv
// Combinational rotating-priority picker: first set request at or after ptr, modulo 4.
// Zero latency; emits all-zero winner when no request is set.
module rr_pick4
  import rr_arbiter_four_pkg::*;
(
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [3:0] o_win_oh,
  output logic [1:0] o_win_idx,
  output logic       o_any
);

  logic [7:0] w_dbl;
  logic [7:0] w_shift;
  logic [3:0] w_rot;
  logic [1:0] w_rot_idx;
  logic [1:0] w_win_idx;

  // Bit k of w_rot is requester (ptr + k) mod 4, so bit 0 is the highest priority.
  assign w_dbl   = {i_req, i_req};
  assign w_shift = w_dbl >> i_ptr;
  assign w_rot   = w_shift[3:0];

  always_comb begin
    w_rot_idx = IDX_0;
    if (w_rot[0])      w_rot_idx = IDX_0;
    else if (w_rot[1]) w_rot_idx = IDX_1;
    else if (w_rot[2]) w_rot_idx = IDX_2;
    else if (w_rot[3]) w_rot_idx = IDX_3;
  end

  assign w_win_idx = w_rot_idx + i_ptr;
  assign o_any     = |i_req;
  assign o_win_oh  = o_any ? idx_to_oh(w_win_idx) : 4'b0000;
  assign o_win_idx = o_any ? w_win_idx : IDX_0;

endmodule

// File: rtl/rr_arbiter_four.sv
// Four-way round-robin arbiter with release-on-done/drop/hold-timeout and one idle cycle between grants.
// Grant appears one cycle after request is sampled; owner holds until release, losers simply wait.
module rr_arbiter_four
  import rr_arbiter_four_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout,
  output logic       none
);

  logic [0:0]       r_state;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_gnt;
  logic [1:0]       r_idx;
  logic             r_vld;
  logic             r_timeout;

  logic [3:0] w_win_oh;
  logic [1:0] w_win_idx;
  logic       w_any;
  logic       w_owner_req;
  logic       w_hold_exp;
  logic       w_release;

  rr_pick4 u_pick (
    .i_req     (req),
    .i_ptr     (r_ptr),
    .o_win_oh  (w_win_oh),
    .o_win_idx (w_win_idx),
    .o_any     (w_any)
  );

  assign w_owner_req = req[r_idx];
  assign w_hold_exp  = (MAX_HOLD != 0) && (r_cnt == CNT_W'(MAX_HOLD - 1));
  assign w_release   = done | ~w_owner_req | w_hold_exp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= IDX_0;
      r_cnt     <= '0;
      r_gnt     <= 4'b0000;
      r_idx     <= IDX_0;
      r_vld     <= 1'b0;
      r_timeout <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_timeout <= 1'b0;
      if (w_any) begin
        r_state <= ST_GRANT;
        r_gnt   <= w_win_oh;
        r_idx   <= w_win_idx;
        r_vld   <= 1'b1;
        r_cnt   <= '0;
      end
    end else if (w_release) begin
      r_state   <= ST_IDLE;
      r_gnt     <= 4'b0000;
      r_idx     <= IDX_0;
      r_vld     <= 1'b0;
      r_ptr     <= r_idx + 2'd1;
      // Timer-only revocation is flagged; an explicit done or a drop wins.
      r_timeout <= w_hold_exp & ~done & w_owner_req;
    end else begin
      r_timeout <= 1'b0;
      if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_idx;
  assign gnt_valid = r_vld;
  assign timeout   = r_timeout;
  assign none      = (req == 4'b0000);

endmodule

// File: tb/tb_rr_arbiter_four.sv
// Directed bench for rr_arbiter_four: owner/queue-level model checked every cycle plus literal checkpoints.
module tb_rr_arbiter_four;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;
  logic       none;

  int n_chk = 0;
  int n_fail = 0;

  // Model state: who owns the resource (-1 = nobody), next-priority requester,
  // number of cycles the current owner has held, and the timeout pulse.
  int m_owner = -1;
  int m_ptr = 0;
  int m_held = 0;
  bit m_to = 1'b0;

  rr_arbiter_four #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout),
    .none      (none)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_owner = -1;
        m_ptr = 0;
        m_held = 0;
        m_to = 1'b0;
      end else if (m_owner < 0) begin
        m_to = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (m_owner < 0 && req[(m_ptr + k) % 4]) begin
            m_owner = (m_ptr + k) % 4;
            m_held = 1;
          end
        end
      end else begin
        if (done || !req[m_owner] || (MAX_HOLD != 0 && m_held == MAX_HOLD)) begin
          m_to = !done && req[m_owner] && (MAX_HOLD != 0 && m_held == MAX_HOLD);
          m_ptr = (m_owner + 1) % 4;
          m_owner = -1;
        end else begin
          m_to = 1'b0;
          m_held++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("cyc_gnt", int'(gnt), (m_owner < 0) ? 0 : (1 << m_owner));
      chk("cyc_idx", int'(gnt_idx), (m_owner < 0) ? 0 : m_owner);
      chk("cyc_valid", int'(gnt_valid), (m_owner < 0) ? 0 : 1);
      chk("cyc_timeout", int'(timeout), int'(m_to));
      chk("cyc_none", int'(none), (req == 4'b0000) ? 1 : 0);
    end
  end

  logic [3:0] rot_oh [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int         rot_ix [5] = '{0, 1, 2, 3, 0};

  initial begin
    // Reset and idle with no requests.
    #2;
    tick(); tick();
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_idx", int'(gnt_idx), 0);
    chk("rst_valid", int'(gnt_valid), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_none", int'(none), 1);
    rst = 1'b0;
    tick(); tick(); tick();
    chk("idle_gnt", int'(gnt), 0);
    chk("idle_none", int'(none), 1);

    // Single request, release with done, immediate re-grant.
    req = 4'b0100;
    tick();
    chk("single_gnt", int'(gnt), 4'b0100);
    chk("single_idx", int'(gnt_idx), 2);
    chk("single_valid", int'(gnt_valid), 1);
    done = 1'b1;
    tick();
    chk("single_rel", int'(gnt), 0);
    done = 1'b0;
    tick();
    chk("single_regnt", int'(gnt), 4'b0100);
    req = 4'b0000;
    tick();
    chk("drop_rel", int'(gnt), 0);
    tick();

    // Rotation from ptr 0 with everyone requesting.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rot_gnt", int'(gnt), int'(rot_oh[k]));
      chk("rot_idx", int'(gnt_idx), rot_ix[k]);
      done = 1'b1;
      tick();
      chk("rot_dead", int'(gnt), 0);
      done = 1'b0;
    end

    // Wrap: owner 3 releases, requester 0 beats 3.
    req = 4'b1000;
    tick();
    chk("wrap_own3", int'(gnt), 4'b1000);
    req = 4'b1001;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    chk("wrap_gnt", int'(gnt), 4'b0001);
    chk("wrap_idx", int'(gnt_idx), 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    req = 4'b0000;
    tick();

    // Hold timeout: requester 1 alone, done never asserted.
    req = 4'b0010;
    tick();
    for (int i = 0; i < MAX_HOLD; i++) begin
      chk("to_hold", int'(gnt), 4'b0010);
      chk("to_nopulse", int'(timeout), 0);
      tick();
    end
    chk("to_rel", int'(gnt), 0);
    chk("to_pulse", int'(timeout), 1);
    chk("to_model_ptr", m_ptr, 2);
    tick();
    chk("to_regnt", int'(gnt), 4'b0010);
    chk("to_pulse_end", int'(timeout), 0);

    // Owner 1 drops its request together with done: one release, no timeout.
    req = 4'b1101;
    done = 1'b1;
    tick();
    chk("dd_rel", int'(gnt), 0);
    chk("dd_timeout", int'(timeout), 0);
    done = 1'b0;
    tick();
    chk("dd_next", int'(gnt), 4'b0100);
    chk("dd_next_idx", int'(gnt_idx), 2);

    // Asynchronous reset in the middle of a grant.
    tick();
    #1;
    rst = 1'b1;
    #1;
    chk("arst_gnt", int'(gnt), 0);
    chk("arst_idx", int'(gnt_idx), 0);
    chk("arst_valid", int'(gnt_valid), 0);
    tick();
    rst = 1'b0;
    req = 4'b0000;
    done = 1'b1;
    tick();
    chk("idle_done_gnt", int'(gnt), 0);
    done = 1'b0;
    req = 4'b0110;
    tick();
    chk("post_rst_gnt", int'(gnt), 4'b0010);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
